hyperbus_tx_ddr_feeder: RTL and testbench

//  Transmit-side stage directly upstream of the per-bit DDR output muxes of the HyperBus PHY.

---
 rtl/hyperbus_tx_pkg.sv | 30 +++
 rtl/hyperbus_tx_fifo.sv | 48 ++++
 rtl/hyperbus_tx_ddr_feeder.sv | 191 +++++++++++++++++++
 tb/tb_hyperbus_tx_ddr_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_tx_pkg.sv
// hyperbus_tx_pkg: shared state encoding, word type and CA byte helpers
// for the HyperBus transmit DDR feeder.
package hyperbus_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CA,
      LAT,
      DATA,
      END
   } tx_state_e;

   localparam int unsigned CA_CYCLES = 3;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  strb;
   } tx_word_t;

   // Rising-edge CA byte for CA cycle k (k=0 is the first, carrying ca[47:40]).
   function automatic logic [7:0] ca_rise_byte(input logic [47:0] ca, input int unsigned k);
      return ca[47 - 16*k -: 8];
   endfunction

   // Falling-edge CA byte for CA cycle k.
   function automatic logic [7:0] ca_fall_byte(input logic [47:0] ca, input int unsigned k);
      return ca[39 - 16*k -: 8];
   endfunction

endpackage

// File: rtl/hyperbus_tx_fifo.sv
// hyperbus_tx_fifo: small write-data buffer between the host stream and the
// DDR feeder. Head entry is visible combinationally; push and pop may
// happen in the same cycle, including while full.
module hyperbus_tx_fifo
   import hyperbus_tx_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  tx_word_t wdata_i,
   input  logic     pop_i,
   output tx_word_t rdata_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   tx_word_t           mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; reset flushes the buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage write; a full-buffer push lands in the slot being popped this cycle.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/hyperbus_tx_ddr_feeder.sv
// hyperbus_tx_ddr_feeder: sequences CA, write latency and write data into
// per-cycle rise/fall byte pairs for the HyperBus PHY DDR output muxes.
// Optional macro HYPERBUS_TX_MASK_EN: drive RWDS from the byte strobes
// (1 = masked byte); when undefined RWDS values stay 0 and strobes are ignored.
module hyperbus_tx_ddr_feeder
   import hyperbus_tx_pkg::*;
#(
   parameter int unsigned LEN_W  = 16,
   parameter int unsigned LAT_W  = 5,
   parameter int unsigned FIFO_D = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [47:0]      ca_i,
   input  logic [LAT_W-1:0] lat_cycles_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [15:0]      tx_data_i,
   input  logic [1:0]       tx_strb_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [7:0]       dq_rise_o,
   output logic [7:0]       dq_fall_o,
   output logic             dq_oe_o,
   output logic             rwds_rise_o,
   output logic             rwds_fall_o,
   output logic             rwds_oe_o,
   output logic             ck_en_o,
   output logic             busy_o,
   output logic             done_o
);

   tx_state_e        state_q;
   logic [47:0]      ca_q;
   logic [LAT_W-1:0] lat_q;
   logic [LAT_W-1:0] lat_cnt_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] word_cnt_q;
   logic [1:0]       ca_cnt_q;
   logic             ready_en_q;

   logic             ca_last;
   logic             want_data;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   tx_word_t         fifo_wdata;
   tx_word_t         fifo_head;
   logic             rwds_rise_d;
   logic             rwds_fall_d;

   assign ca_last    = (ca_cnt_q == 2'(CA_CYCLES - 1));
   assign fifo_pop   = want_data & ~fifo_empty;
   assign tx_ready_o = ready_en_q & (~fifo_full | fifo_pop);
   assign fifo_push  = tx_valid_i & tx_ready_o;
   assign fifo_wdata = '{data: tx_data_i, strb: tx_strb_i};

`ifdef HYPERBUS_TX_MASK_EN
   assign rwds_rise_d = ~fifo_head.strb[1];
   assign rwds_fall_d = ~fifo_head.strb[0];
`else
   logic unused_strb;
   assign unused_strb = ^fifo_head.strb;
   assign rwds_rise_d = 1'b0;
   assign rwds_fall_d = 1'b0;
`endif

   hyperbus_tx_fifo #(
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The registered outputs show the phase held in state_q, so the cycle that
   // sets up the next DATA cycle is the one that pops the buffer.
   always_comb begin
      want_data = 1'b0;
      case (state_q)
         CA:      want_data = ca_last && !ca_q[47] && (len_q != '0) && (lat_q == '0);
         LAT:     want_data = (lat_cnt_q <= LAT_W'(1));
         DATA:    want_data = (word_cnt_q != len_q);
         default: want_data = 1'b0;
      endcase
   end

   // Ready is held low until the first clock after reset release.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ready_en_q <= 1'b0;
      else         ready_en_q <= 1'b1;
   end

   // Transaction sequencer with registered PHY-side outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ca_q        <= '0;
         lat_q       <= '0;
         len_q       <= '0;
         lat_cnt_q   <= '0;
         word_cnt_q  <= '0;
         ca_cnt_q    <= '0;
         dq_rise_o   <= '0;
         dq_fall_o   <= '0;
         dq_oe_o     <= 1'b0;
         rwds_rise_o <= 1'b0;
         rwds_fall_o <= 1'b0;
         rwds_oe_o   <= 1'b0;
         ck_en_o     <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (want_data) begin
            // Empty buffer pauses CK and holds the last data values.
            state_q   <= DATA;
            dq_oe_o   <= 1'b1;
            rwds_oe_o <= 1'b1;
            ck_en_o   <= fifo_pop;
            if (fifo_pop) begin
               dq_rise_o   <= fifo_head.data[15:8];
               dq_fall_o   <= fifo_head.data[7:0];
               rwds_rise_o <= rwds_rise_d;
               rwds_fall_o <= rwds_fall_d;
               word_cnt_q  <= word_cnt_q + LEN_W'(1);
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     state_q    <= CA;
                     ca_q       <= ca_i;
                     lat_q      <= lat_cycles_i;
                     len_q      <= len_i;
                     ca_cnt_q   <= '0;
                     word_cnt_q <= '0;
                     dq_rise_o  <= ca_i[47:40];
                     dq_fall_o  <= ca_i[39:32];
                     dq_oe_o    <= 1'b1;
                     ck_en_o    <= 1'b1;
                     busy_o     <= 1'b1;
                  end
               end
               CA: begin
                  if (!ca_last) begin
                     ca_cnt_q  <= ca_cnt_q + 2'd1;
                     dq_rise_o <= ca_rise_byte(ca_q, 32'(ca_cnt_q) + 32'd1);
                     dq_fall_o <= ca_fall_byte(ca_q, 32'(ca_cnt_q) + 32'd1);
                  end else if (ca_q[47] || (len_q == '0)) begin
                     state_q   <= END;
                     dq_oe_o   <= 1'b0;
                     rwds_oe_o <= 1'b0;
                     ck_en_o   <= 1'b0;
                     done_o    <= 1'b1;
                  end else begin
                     state_q   <= LAT;
                     lat_cnt_q <= lat_q;
                     dq_oe_o   <= 1'b0;
                     ck_en_o   <= 1'b1;
                  end
               end
               LAT: begin
                  lat_cnt_q <= lat_cnt_q - LAT_W'(1);
               end
               DATA: begin
                  state_q   <= END;
                  dq_oe_o   <= 1'b0;
                  rwds_oe_o <= 1'b0;
                  ck_en_o   <= 1'b0;
                  done_o    <= 1'b1;
               end
               END: begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hyperbus_tx_ddr_feeder.sv
// tb_hyperbus_tx_ddr_feeder: directed bench for the HyperBus TX DDR feeder.
`timescale 1ns/1ps
module tb_hyperbus_tx_ddr_feeder;

`ifdef HYPERBUS_TX_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [47:0] ca_i = '0;
   logic [4:0]  lat_cycles_i = '0;
   logic [15:0] len_i = '0;
   logic [15:0] tx_data_i = '0;
   logic [1:0]  tx_strb_i = '0;
   logic        tx_valid_i = 1'b0;
   logic        tx_ready_o;
   logic [7:0]  dq_rise_o, dq_fall_o;
   logic        dq_oe_o, rwds_rise_o, rwds_fall_o, rwds_oe_o, ck_en_o, busy_o, done_o;

   always #5 clk_i = ~clk_i;

   hyperbus_tx_ddr_feeder #(
      .LEN_W  (16),
      .LAT_W  (5),
      .FIFO_D (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .ca_i         (ca_i),
      .lat_cycles_i (lat_cycles_i),
      .len_i        (len_i),
      .tx_data_i    (tx_data_i),
      .tx_strb_i    (tx_strb_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .dq_rise_o    (dq_rise_o),
      .dq_fall_o    (dq_fall_o),
      .dq_oe_o      (dq_oe_o),
      .rwds_rise_o  (rwds_rise_o),
      .rwds_fall_o  (rwds_fall_o),
      .rwds_oe_o    (rwds_oe_o),
      .ck_en_o      (ck_en_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cyc = -1;

   // Word feeder: word i is offered once cyc >= feed_at[i].
   logic [15:0] feed_d [16];
   logic [1:0]  feed_s [16];
   int          feed_at [16];
   int          feed_n = 0;
   int          feed_idx = 0;

   // Per-cycle trace of one transaction; index 1 = first cycle after start.
   logic [7:0] r_rise [64];
   logic [7:0] r_fall [64];
   logic       r_dqoe [64];
   logic       r_rwoe [64];
   logic       r_ck   [64];
   logic       r_done [64];
   logic       r_busy [64];
   logic       r_rr   [64];
   logic       r_rf   [64];
   logic       r_rdy  [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      if (feed_idx < feed_n && cyc >= feed_at[feed_idx]) begin
         tx_valid_i = 1'b1;
         tx_data_i  = feed_d[feed_idx];
         tx_strb_i  = feed_s[feed_idx];
      end else begin
         tx_valid_i = 1'b0;
         tx_data_i  = '0;
         tx_strb_i  = '0;
      end
   endtask

   task automatic new_feed();
      feed_n   = 0;
      feed_idx = 0;
      cyc      = -1000;
      drive();
   endtask

   task automatic add_word(input logic [15:0] d, input logic [1:0] s, input int at);
      feed_d[feed_n]  = d;
      feed_s[feed_n]  = s;
      feed_at[feed_n] = at;
      feed_n++;
      drive();
   endtask

   // One clock: inputs/outputs are stable between posedge+1 and the next posedge.
   task automatic step();
      logic fire;
      fire = tx_valid_i && tx_ready_o;
      @(posedge clk_i);
      #1;
      cyc++;
      if (fire) feed_idx++;
      drive();
   endtask

   task automatic record(input int c);
      r_rise[c] = dq_rise_o;
      r_fall[c] = dq_fall_o;
      r_dqoe[c] = dq_oe_o;
      r_rwoe[c] = rwds_oe_o;
      r_ck[c]   = ck_en_o;
      r_done[c] = done_o;
      r_busy[c] = busy_o;
      r_rr[c]   = rwds_rise_o;
      r_rf[c]   = rwds_fall_o;
      r_rdy[c]  = tx_ready_o;
   endtask

   // Runs one transaction, recording until one cycle past done_o (bounded by maxc).
   task automatic run_txn(input logic [47:0] ca, input logic [4:0] lat, input logic [15:0] len,
                          input bit hold, input int maxc);
      ca_i         = ca;
      lat_cycles_i = lat;
      len_i        = len;
      start_i      = 1'b1;
      cyc          = 0;
      done_cyc     = -1;
      drive();
      for (int c = 1; c <= maxc; c++) begin
         step();
         if (!hold) start_i = 1'b0;
         record(c);
         if (done_o && done_cyc < 0) begin
            done_cyc = c;
            start_i  = 1'b0;
         end
         if (done_cyc >= 0 && c > done_cyc) break;
      end
      start_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_dq_oe", 32'(dq_oe_o), 0);
      chk("rst_ck_en", 32'(ck_en_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_ready", 32'(tx_ready_o), 0);
      chk("rst_dq_rise", 32'(dq_rise_o), 0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step();
      chk("rel_ready", 32'(tx_ready_o), 1);

      // 1: write, lat=6, len=4, two words preloaded, rest streamed
      new_feed();
      add_word(16'hA1B2, 2'b11, -1000);
      add_word(16'hC3D4, 2'b11, -1000);
      add_word(16'hE5F6, 2'b11, -1000);
      add_word(16'h0718, 2'b11, -1000);
      repeat (3) step();
      chk("t1_ready_full", 32'(tx_ready_o), 0);
      run_txn(48'h0000_0000_1000, 5'd6, 16'd4, 1'b0, 40);
      chk("t1_done_cyc", 32'(done_cyc), 14);
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("t1_ca_oe%0d", c), 32'(r_dqoe[c]), 1);
         chk($sformatf("t1_ca_ck%0d", c), 32'(r_ck[c]), 1);
         chk($sformatf("t1_ca_busy%0d", c), 32'(r_busy[c]), 1);
      end
      chk("t1_ca3_rise", 32'(r_rise[3]), 32'h10);
      chk("t1_ca3_fall", 32'(r_fall[3]), 32'h00);
      for (int c = 4; c <= 9; c++) begin
         chk($sformatf("t1_lat_ck%0d", c), 32'(r_ck[c]), 1);
         chk($sformatf("t1_lat_oe%0d", c), 32'(r_dqoe[c]), 0);
      end
      chk("t1_ready_c8", 32'(r_rdy[8]), 0);
      chk("t1_ready_pop_c9", 32'(r_rdy[9]), 1);
      chk("t1_d10_rise", 32'(r_rise[10]), 32'hA1);
      chk("t1_d10_fall", 32'(r_fall[10]), 32'hB2);
      chk("t1_d11_rise", 32'(r_rise[11]), 32'hC3);
      chk("t1_d12_fall", 32'(r_fall[12]), 32'hF6);
      chk("t1_d13_rise", 32'(r_rise[13]), 32'h07);
      chk("t1_d13_fall", 32'(r_fall[13]), 32'h18);
      for (int c = 10; c <= 13; c++) begin
         chk($sformatf("t1_d_ck%0d", c), 32'(r_ck[c]), 1);
         chk($sformatf("t1_d_rwoe%0d", c), 32'(r_rwoe[c]), 1);
      end
      chk("t1_end_oe", 32'(r_dqoe[14]), 0);
      chk("t1_end_rwoe", 32'(r_rwoe[14]), 0);
      chk("t1_end_ck", 32'(r_ck[14]), 0);
      chk("t1_end_busy", 32'(r_busy[14]), 1);
      chk("t1_idle_busy", 32'(r_busy[15]), 0);
      chk("t1_idle_done", 32'(r_done[15]), 0);
      repeat (2) step();

      // 2: stall, lat=2, len=3, words 2/3 become valid in cycle 9
      new_feed();
      add_word(16'h1122, 2'b11, -1000);
      add_word(16'h3344, 2'b11, 9);
      add_word(16'h5566, 2'b11, 9);
      repeat (2) step();
      run_txn(48'h2000_0000_0004, 5'd2, 16'd3, 1'b0, 40);
      chk("t2_done_cyc", 32'(done_cyc), 13);
      chk("t2_d6_ck", 32'(r_ck[6]), 1);
      chk("t2_d6_rise", 32'(r_rise[6]), 32'h11);
      for (int c = 7; c <= 10; c++) begin
         chk($sformatf("t2_stall_ck%0d", c), 32'(r_ck[c]), 0);
         chk($sformatf("t2_stall_oe%0d", c), 32'(r_dqoe[c]), 1);
         chk($sformatf("t2_stall_rise%0d", c), 32'(r_rise[c]), 32'h11);
         chk($sformatf("t2_stall_fall%0d", c), 32'(r_fall[c]), 32'h22);
      end
      chk("t2_d11_ck", 32'(r_ck[11]), 1);
      chk("t2_d11_rise", 32'(r_rise[11]), 32'h33);
      chk("t2_d11_fall", 32'(r_fall[11]), 32'h44);
      chk("t2_d12_rise", 32'(r_rise[12]), 32'h55);
      chk("t2_d12_fall", 32'(r_fall[12]), 32'h66);
      repeat (2) step();

      // 3: read, start held high while busy (must be ignored)
      new_feed();
      run_txn(48'hC0FF_EE00_1234, 5'd6, 16'd8, 1'b1, 20);
      chk("t3_done_cyc", 32'(done_cyc), 4);
      chk("t3_c1_rise", 32'(r_rise[1]), 32'hC0);
      chk("t3_c1_fall", 32'(r_fall[1]), 32'hFF);
      chk("t3_c2_rise", 32'(r_rise[2]), 32'hEE);
      chk("t3_c3_rise", 32'(r_rise[3]), 32'h12);
      chk("t3_c3_fall", 32'(r_fall[3]), 32'h34);
      for (int c = 1; c <= 4; c++) chk($sformatf("t3_ready%0d", c), 32'(r_rdy[c]), 1);
      chk("t3_end_ck", 32'(r_ck[4]), 0);
      chk("t3_after_busy", 32'(r_busy[5]), 0);
      chk("t3_after_oe", 32'(r_dqoe[5]), 0);
      repeat (2) step();

      // 4: zero latency, len=1
      new_feed();
      add_word(16'hBEEF, 2'b11, -1000);
      step();
      run_txn(48'h1122_3344_5566, 5'd0, 16'd1, 1'b0, 20);
      chk("t4_done_cyc", 32'(done_cyc), 5);
      chk("t4_c1_rise", 32'(r_rise[1]), 32'h11);
      chk("t4_c2_fall", 32'(r_fall[2]), 32'h44);
      chk("t4_c3_rise", 32'(r_rise[3]), 32'h55);
      chk("t4_d4_ck", 32'(r_ck[4]), 1);
      chk("t4_d4_oe", 32'(r_dqoe[4]), 1);
      chk("t4_d4_rise", 32'(r_rise[4]), 32'hBE);
      chk("t4_d4_fall", 32'(r_fall[4]), 32'hEF);
      repeat (2) step();

      // 5: async reset during DATA word 2 of 4, then a clean transaction
      new_feed();
      add_word(16'h0102, 2'b11, -1000);
      add_word(16'h0304, 2'b11, -1000);
      add_word(16'h0506, 2'b11, -1000);
      add_word(16'h0708, 2'b11, -1000);
      repeat (2) step();
      ca_i = 48'h3000_0000_0000;
      lat_cycles_i = 5'd1;
      len_i = 16'd4;
      start_i = 1'b1;
      cyc = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         start_i = 1'b0;
      end
      chk("t5_pre_rise", 32'(dq_rise_o), 32'h03);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_rise", 32'(dq_rise_o), 0);
      chk("t5_rst_oe", 32'(dq_oe_o), 0);
      chk("t5_rst_rwoe", 32'(rwds_oe_o), 0);
      chk("t5_rst_ck", 32'(ck_en_o), 0);
      chk("t5_rst_busy", 32'(busy_o), 0);
      chk("t5_rst_ready", 32'(tx_ready_o), 0);
      new_feed();
      repeat (2) step();
      rst_ni = 1'b1;
      step();
      chk("t5_rel_ready", 32'(tx_ready_o), 1);
      add_word(16'hAAAB, 2'b11, -1000);
      add_word(16'hBBBC, 2'b11, -1000);
      repeat (2) step();
      run_txn(48'h0000_0000_0000, 5'd0, 16'd2, 1'b0, 20);
      chk("t5_done_cyc", 32'(done_cyc), 6);
      chk("t5_d4_rise", 32'(r_rise[4]), 32'hAA);
      chk("t5_d5_rise", 32'(r_rise[5]), 32'hBB);
      chk("t5_d5_fall", 32'(r_fall[5]), 32'hBC);
      repeat (2) step();

      // 6: byte masks on RWDS
      new_feed();
      add_word(16'h5A5A, 2'b01, -1000);
      add_word(16'hA5A5, 2'b10, -1000);
      repeat (2) step();
      run_txn(48'h0000_0000_0000, 5'd0, 16'd2, 1'b0, 20);
      chk("t6_done_cyc", 32'(done_cyc), 6);
      chk("t6_d4_rwoe", 32'(r_rwoe[4]), 1);
      chk("t6_d4_rr", 32'(r_rr[4]), MASK ? 1 : 0);
      chk("t6_d4_rf", 32'(r_rf[4]), 0);
      chk("t6_d5_rr", 32'(r_rr[5]), 0);
      chk("t6_d5_rf", 32'(r_rf[5]), MASK ? 1 : 0);
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
